// File: rtl/up_agg_pkg.sv
// ---------------------------------------------------------------------------
// up_agg_pkg
// Shared definitions for the up-bus channel aggregator:
//   - wd_state_t             : request watchdog state (IDLE, WAIT)
//   - DEFAULT_TIMEOUT_RDATA  : read data returned when a read times out
//   - clog2()                : ceiling log2, sizes the watchdog counter
// ---------------------------------------------------------------------------
package up_agg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wd_state_t;

    localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_DEAD;

    // Ceiling log2; a counter of this width holds 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/up_ack_watchdog.sv
// ---------------------------------------------------------------------------
// up_ack_watchdog
// Tracks one outstanding up-bus request (read or write) and classifies the
// slice acks seen in each cycle. All outputs are combinational events for
// the current cycle; the top level registers them.
// Ports:
//   up_clk, up_rstn : bus clock, asynchronous active-low reset
//   i_req           : request pulse
//   i_ack           : per-slice ack vector
//   o_fwd_ack       : an ack completes the outstanding request this cycle
//   o_timeout       : last waiting cycle passed with no ack
//   o_err_inc       : collision, stray ack or request while waiting
// ---------------------------------------------------------------------------
module up_ack_watchdog
    import up_agg_pkg::*;
#(
    parameter int NUM_SLICES     = 3,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  up_clk,
    input  logic                  up_rstn,
    input  logic                  i_req,
    input  logic [NUM_SLICES-1:0] i_ack,
    output logic                  o_fwd_ack,
    output logic                  o_timeout,
    output logic                  o_err_inc
);

    localparam int                      CW       = clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]           LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_SLICES-1:0]   ACK_ONE  = NUM_SLICES'(1);

    wd_state_t     r_state;
    wd_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_any_ack;
    logic          w_multi_ack;

    assign w_any_ack   = |i_ack;
    // Clearing the lowest set bit leaves something only if two or more acks are set.
    assign w_multi_ack = |(i_ack & (i_ack - ACK_ONE));

    // State and wait-counter registers.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and per-cycle event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_fwd_ack   = 1'b0;
        o_timeout   = 1'b0;
        o_err_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                // Nothing outstanding: any ack is stray or late.
                o_err_inc = w_any_ack;
                if (i_req) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (w_any_ack) begin
                    o_fwd_ack = 1'b1;
                    o_err_inc = w_multi_ack;
                    // A request arriving with the ack starts a fresh wait.
                    if (i_req) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else if (i_req) begin
                    // Request while one is still outstanding: restart the wait.
                    o_err_inc   = 1'b1;
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST_CNT) begin
                    o_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/up_adc_chan_aggregator.sv
// ---------------------------------------------------------------------------
// up_adc_chan_aggregator
// Merges the up-bus responses of NUM_SLICES register slices into one
// registered response, ORs per-channel status for the common block and
// answers requests that no slice acknowledges.
// Ports:
//   up_clk, up_rstn          : bus clock, asynchronous active-low reset
//   up_wreq, up_rreq         : request pulses (observed only)
//   up_wack_s, up_rack_s     : per-slice write / read acks
//   up_rdata_s               : per-slice read data, slice i at [32i+31:32i]
//   up_pn_err_s, up_pn_oos_s,
//   up_or_s                  : per-channel status (NUM_SLICES-1 channels)
//   up_wack, up_rack,
//   up_rdata                 : aggregated response
//   up_status_*              : registered OR of channel status
//   up_rd_timeout,
//   up_wr_timeout            : one-cycle pulse when the watchdog answers
//   up_err_count             : saturating error count, cleared by reset only
// A single-slice build keeps one status bit per port; tie it to 0.
// ---------------------------------------------------------------------------
module up_adc_chan_aggregator
    import up_agg_pkg::*;
#(
    parameter int          NUM_SLICES     = 3,
    parameter int          TIMEOUT_CYCLES = 32,
    parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
    input  logic                                             up_clk,
    input  logic                                             up_rstn,
    input  logic                                             up_wreq,
    input  logic                                             up_rreq,
    input  logic [NUM_SLICES-1:0]                            up_wack_s,
    input  logic [NUM_SLICES-1:0]                            up_rack_s,
    input  logic [32*NUM_SLICES-1:0]                         up_rdata_s,
    input  logic [((NUM_SLICES > 1) ? NUM_SLICES-2 : 0):0]   up_pn_err_s,
    input  logic [((NUM_SLICES > 1) ? NUM_SLICES-2 : 0):0]   up_pn_oos_s,
    input  logic [((NUM_SLICES > 1) ? NUM_SLICES-2 : 0):0]   up_or_s,
    output logic                                             up_wack,
    output logic                                             up_rack,
    output logic [31:0]                                      up_rdata,
    output logic                                             up_status_pn_err,
    output logic                                             up_status_pn_oos,
    output logic                                             up_status_or,
    output logic                                             up_rd_timeout,
    output logic                                             up_wr_timeout,
    output logic [7:0]                                       up_err_count
);

    logic        w_rd_fwd;
    logic        w_rd_to;
    logic        w_rd_err;
    logic        w_wr_fwd;
    logic        w_wr_to;
    logic        w_wr_err;
    logic [31:0] w_rdata_or;
    logic [31:0] w_rdata_nxt;
    logic [8:0]  w_err_sum;
    logic [7:0]  w_err_nxt;

    logic        r_rack;
    logic        r_wack;
    logic [31:0] r_rdata;
    logic        r_rd_to;
    logic        r_wr_to;
    logic        r_pn_err;
    logic        r_pn_oos;
    logic        r_or;
    logic [7:0]  r_err_count;

    up_ack_watchdog #(
        .NUM_SLICES     (NUM_SLICES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rd_wd (
        .up_clk    (up_clk),
        .up_rstn   (up_rstn),
        .i_req     (up_rreq),
        .i_ack     (up_rack_s),
        .o_fwd_ack (w_rd_fwd),
        .o_timeout (w_rd_to),
        .o_err_inc (w_rd_err)
    );

    up_ack_watchdog #(
        .NUM_SLICES     (NUM_SLICES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wr_wd (
        .up_clk    (up_clk),
        .up_rstn   (up_rstn),
        .i_req     (up_wreq),
        .i_ack     (up_wack_s),
        .o_fwd_ack (w_wr_fwd),
        .o_timeout (w_wr_to),
        .o_err_inc (w_wr_err)
    );

    // OR of all slice read data; idle slices drive zero.
    always_comb begin
        w_rdata_or = 32'h0000_0000;
        for (int i = 0; i < NUM_SLICES; i++) begin
            w_rdata_or = w_rdata_or | up_rdata_s[32*i +: 32];
        end
    end

    // Read data only leaves the block together with a read ack, so stray
    // acks cannot leak their data onto the bus.
    always_comb begin
        if (w_rd_fwd) begin
            w_rdata_nxt = w_rdata_or;
        end else if (w_rd_to) begin
            w_rdata_nxt = TIMEOUT_RDATA;
        end else begin
            w_rdata_nxt = 32'h0000_0000;
        end
    end

    // Saturating add of up to two error events per cycle.
    always_comb begin
        w_err_sum = {1'b0, r_err_count} + {8'h00, w_rd_err} + {8'h00, w_wr_err};
        if (w_err_sum[8]) begin
            w_err_nxt = 8'hFF;
        end else begin
            w_err_nxt = w_err_sum[7:0];
        end
    end

    // Registered response, status and error counter.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_rack      <= 1'b0;
            r_wack      <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_rd_to     <= 1'b0;
            r_wr_to     <= 1'b0;
            r_pn_err    <= 1'b0;
            r_pn_oos    <= 1'b0;
            r_or        <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            r_rack      <= w_rd_fwd | w_rd_to;
            r_wack      <= w_wr_fwd | w_wr_to;
            r_rdata     <= w_rdata_nxt;
            r_rd_to     <= w_rd_to;
            r_wr_to     <= w_wr_to;
            r_pn_err    <= |up_pn_err_s;
            r_pn_oos    <= |up_pn_oos_s;
            r_or        <= |up_or_s;
            r_err_count <= w_err_nxt;
        end
    end

    assign up_rack          = r_rack;
    assign up_wack          = r_wack;
    assign up_rdata         = r_rdata;
    assign up_rd_timeout    = r_rd_to;
    assign up_wr_timeout    = r_wr_to;
    assign up_status_pn_err = r_pn_err;
    assign up_status_pn_oos = r_pn_oos;
    assign up_status_or     = r_or;
    assign up_err_count     = r_err_count;

endmodule

// File: tb/tb_up_adc_chan_aggregator.sv
// ---------------------------------------------------------------------------
// tb_up_adc_chan_aggregator
// Transaction-level bench: each issued request records the cycle and data of
// the response it must produce in a per-direction queue; a monitor on the
// falling edge compares every cycle's response against the queue heads.
// ---------------------------------------------------------------------------
module tb_up_adc_chan_aggregator;

    localparam int          NS      = 3;
    localparam int          T       = 32;
    localparam logic [31:0] TO_DATA = 32'hDEAD_DEAD;

    logic              up_clk     = 1'b0;
    logic              up_rstn    = 1'b0;
    logic              up_wreq    = 1'b0;
    logic              up_rreq    = 1'b0;
    logic [NS-1:0]     up_wack_s  = '0;
    logic [NS-1:0]     up_rack_s  = '0;
    logic [32*NS-1:0]  up_rdata_s = '0;
    logic [NS-2:0]     up_pn_err_s = '0;
    logic [NS-2:0]     up_pn_oos_s = '0;
    logic [NS-2:0]     up_or_s     = '0;
    logic              up_wack;
    logic              up_rack;
    logic [31:0]       up_rdata;
    logic              up_status_pn_err;
    logic              up_status_pn_oos;
    logic              up_status_or;
    logic              up_rd_timeout;
    logic              up_wr_timeout;
    logic [7:0]        up_err_count;

    up_adc_chan_aggregator #(
        .NUM_SLICES     (NS),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_RDATA  (TO_DATA)
    ) dut (
        .up_clk           (up_clk),
        .up_rstn          (up_rstn),
        .up_wreq          (up_wreq),
        .up_rreq          (up_rreq),
        .up_wack_s        (up_wack_s),
        .up_rack_s        (up_rack_s),
        .up_rdata_s       (up_rdata_s),
        .up_pn_err_s      (up_pn_err_s),
        .up_pn_oos_s      (up_pn_oos_s),
        .up_or_s          (up_or_s),
        .up_wack          (up_wack),
        .up_rack          (up_rack),
        .up_rdata         (up_rdata),
        .up_status_pn_err (up_status_pn_err),
        .up_status_pn_oos (up_status_pn_oos),
        .up_status_or     (up_status_or),
        .up_rd_timeout    (up_rd_timeout),
        .up_wr_timeout    (up_wr_timeout),
        .up_err_count     (up_err_count)
    );

    always #5 up_clk = ~up_clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          to;
    } exp_t;

    exp_t       rd_q[$];
    exp_t       wr_q[$];
    int         cyc     = 0;
    int         tests   = 0;
    int         fails   = 0;
    int         exp_err = 0;
    bit         rand_st = 1'b0;
    logic [2:0] st_exp  = 3'b000;

    always @(posedge up_clk) cyc <= cyc + 1;

    // Status is the OR of the previous cycle's channel inputs.
    always @(posedge up_clk)
        st_exp <= up_rstn ? {|up_or_s, |up_pn_oos_s, |up_pn_err_s} : 3'b000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_side(input bit is_rd, input logic ack, input logic [31:0] data, input logic to);
        exp_t e;
        bit   due;
        due = 1'b0;
        if (is_rd) begin
            while (rd_q.size() > 0 && rd_q[0].cyc < cyc) e = rd_q.pop_front();
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                due = 1'b1;
                e   = rd_q.pop_front();
            end
        end else begin
            while (wr_q.size() > 0 && wr_q[0].cyc < cyc) e = wr_q.pop_front();
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                due = 1'b1;
                e   = wr_q.pop_front();
            end
        end
        chk(is_rd ? "rack" : "wack", {31'b0, ack}, {31'b0, due});
        if (due) begin
            if (is_rd) chk("rdata", data, e.data);
            chk(is_rd ? "rd_timeout" : "wr_timeout", {31'b0, to}, {31'b0, e.to});
        end else begin
            if (is_rd) chk("rdata_idle", data, 32'h0);
            chk(is_rd ? "rd_timeout_idle" : "wr_timeout_idle", {31'b0, to}, 32'h0);
        end
    endtask

    // Monitor: response and status every cycle, away from the active edge.
    always @(negedge up_clk) begin
        check_side(1'b1, up_rack, up_rdata, up_rd_timeout);
        check_side(1'b0, up_wack, 32'h0, up_wr_timeout);
        chk("status", {29'b0, up_status_or, up_status_pn_oos, up_status_pn_err},
            {29'b0, (up_rstn ? st_exp : 3'b000)});
    end

    task automatic tick();
        logic [31:0] r;
        @(posedge up_clk);
        #1;
        if (rand_st) begin
            r = $urandom;
            up_pn_err_s = r[NS-2:0];
            up_pn_oos_s = r[NS+6:8];
            up_or_s     = r[NS+14:16];
        end
    endtask

    task automatic push(input bit is_rd, input int c, input logic [31:0] d, input bit to);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        e.to   = to;
        if (is_rd) rd_q.push_back(e);
        else       wr_q.push_back(e);
    endtask

    task automatic chk_err();
        chk("err_count", {24'b0, up_err_count}, (exp_err > 255) ? 32'd255 : 32'(exp_err));
    endtask

    // Request at cycle t, slices in mask ack at t+k (mask 0: nobody acks).
    task automatic txn(input bit is_rd, input int k, input logic [2:0] mask,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        int          t;
        logic [31:0] v0, v1, v2;
        t  = cyc;
        v0 = mask[0] ? d0 : 32'h0;
        v1 = mask[1] ? d1 : 32'h0;
        v2 = mask[2] ? d2 : 32'h0;
        if (mask != 3'b000 && k <= T) begin
            push(is_rd, t + k + 1, is_rd ? (v0 | v1 | v2) : 32'h0, 1'b0);
            if ($countones(mask) >= 2) exp_err++;
        end else begin
            push(is_rd, t + T + 1, is_rd ? TO_DATA : 32'h0, 1'b1);
            if (mask != 3'b000) exp_err++;
        end
        if (is_rd) up_rreq = 1'b1;
        else       up_wreq = 1'b1;
        tick();
        up_rreq = 1'b0;
        up_wreq = 1'b0;
        repeat (k - 1) tick();
        if (is_rd) begin
            up_rack_s  = mask;
            up_rdata_s = {v2, v1, v0};
        end else begin
            up_wack_s  = mask;
        end
        tick();
        up_rack_s  = '0;
        up_wack_s  = '0;
        up_rdata_s = '0;
        while (cyc < t + T + 5) tick();
        chk_err();
    endtask

    initial begin
        int          t;
        logic [31:0] r;

        repeat (3) tick();
        chk("reset_outputs", {17'b0, up_rack, up_wack, up_status_pn_err, up_status_pn_oos,
                              up_status_or, up_rd_timeout, up_wr_timeout, up_err_count}, 32'h0);
        chk("reset_rdata", up_rdata, 32'h0);
        up_rstn = 1'b1;
        tick();

        // Directed cases.
        txn(1'b1, 2, 3'b010, 32'h0, 32'h1234_5678, 32'h0);
        txn(1'b0, T + 3, 3'b001, 32'h0, 32'h0, 32'h0);
        txn(1'b1, T + 2, 3'b000, 32'h0, 32'h0, 32'h0);
        txn(1'b1, 1, 3'b101, 32'h0000_00F0, 32'hFFFF_FFFF, 32'h0000_0F00);
        txn(1'b0, T, 3'b100, 32'h0, 32'h0, 32'h0);
        txn(1'b1, T, 3'b001, 32'hCAFE_0001, 32'h0, 32'h0);
        txn(1'b1, T + 1, 3'b010, 32'h0, 32'h5555_AAAA, 32'h0);

        // Second read request while waiting restarts the wait.
        t = cyc;
        push(1'b1, t + 3 + T + 1, TO_DATA, 1'b1);
        exp_err++;
        up_rreq = 1'b1;
        tick();
        up_rreq = 1'b0;
        repeat (2) tick();
        up_rreq = 1'b1;
        tick();
        up_rreq = 1'b0;
        while (cyc < t + T + 8) tick();
        chk_err();

        // Ack and new write request in the same cycle.
        t = cyc;
        up_wreq = 1'b1;
        tick();
        up_wreq = 1'b0;
        tick();
        push(1'b0, t + 3, 32'h0, 1'b0);
        push(1'b0, t + 8, 32'h0, 1'b0);
        up_wack_s = 3'b100;
        up_wreq   = 1'b1;
        tick();
        up_wack_s = '0;
        up_wreq   = 1'b0;
        repeat (4) tick();
        up_wack_s = 3'b001;
        tick();
        up_wack_s = '0;
        repeat (3) tick();
        chk_err();

        // One-cycle status pulse.
        up_pn_oos_s = 2'b10;
        tick();
        up_pn_oos_s = 2'b00;
        @(negedge up_clk);
        chk("pn_oos_pulse", {31'b0, up_status_pn_oos}, 32'h1);
        tick();
        @(negedge up_clk);
        chk("pn_oos_clear", {31'b0, up_status_pn_oos}, 32'h0);

        // Randomised transactions with random channel status.
        rand_st = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            txn(r[0], int'($urandom_range(1, T + 3)), r[3:1], $urandom, $urandom, $urandom);
        end
        rand_st     = 1'b0;
        up_pn_err_s = '0;
        up_pn_oos_s = '0;
        up_or_s     = '0;

        // Stray acks on both buses until the counter saturates.
        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            up_rack_s = r[2:0];
            up_wack_s = r[5:3];
            if (r[5:0] == 6'b0) up_rack_s = 3'b010;
            up_rdata_s = {$urandom, $urandom, $urandom};
            exp_err += int'(up_rack_s != 3'b000) + int'(up_wack_s != 3'b000);
            tick();
        end
        up_rack_s  = '0;
        up_wack_s  = '0;
        up_rdata_s = '0;
        repeat (2) tick();
        chk_err();

        // Reset while a read is outstanding: request is abandoned.
        up_rreq = 1'b1;
        tick();
        up_rreq = 1'b0;
        repeat (3) tick();
        up_rstn = 1'b0;
        rd_q.delete();
        wr_q.delete();
        exp_err = 0;
        #1;
        chk("reset_mid_outputs", {17'b0, up_rack, up_wack, up_status_pn_err, up_status_pn_oos,
                                  up_status_or, up_rd_timeout, up_wr_timeout, up_err_count}, 32'h0);
        tick();
        up_rstn = 1'b1;
        repeat (T + 6) tick();
        chk_err();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
